// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encodings, grant width and width helper for the UART arbiter
package uart_pkg;
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOAD    = 3'd1;
    localparam logic [2:0] SEND    = 3'd2;
    localparam logic [2:0] WAIT_HI = 3'd3;
    localparam logic [2:0] WAIT_LO = 3'd4;
    localparam int GRANT_W = 3;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or above ptr with wrap
module rr_pick import uart_pkg::*; #(
    parameter int N = 3
) (
    input  logic [N-1:0]       req,
    input  logic [GRANT_W-1:0] ptr,
    output logic               valid,
    output logic [GRANT_W-1:0] index
);
    logic [N-1:0]       rot;
    logic [GRANT_W-1:0] off;
    logic [GRANT_W:0]   sum;
    always_comb begin
        rot = N'({req, req} >> ptr);
        off = '0;
        for (int k = N - 1; k >= 0; k--) if (rot[k]) off = GRANT_W'(k);
        sum = {1'b0, ptr} + {1'b0, off};
        valid = |req;
        index = (sum >= (GRANT_W + 1)'(N)) ? GRANT_W'(sum - (GRANT_W + 1)'(N)) : sum[GRANT_W-1:0];
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin sharing of one uart_tx between N byte streams
module uart_tx_arbiter import uart_pkg::*; #(
    parameter int N       = 3,
    parameter int TIMEOUT = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req_valid,
    input  logic [8*N-1:0]     req_data,
    input  logic [N-1:0]       req_last,
    output logic [N-1:0]       req_ready,
    output logic               tx_send,
    output logic [7:0]         tx_data,
    input  logic               tx_busy,
    output logic               grant_active,
    output logic [GRANT_W-1:0] grant_id
);
    localparam int CW = (clog2(TIMEOUT + 1) > 0) ? clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TLIM = CW'(TIMEOUT);
    logic [2:0]         state_q, state_d;
    logic [GRANT_W-1:0] grant_q, grant_d, ptr_q, ptr_d, pick_idx, ptr_nxt;
    logic               active_q, active_d, send_q, send_d, last_q, last_d;
    logic               pick_valid, xfer, sel_valid, sel_last;
    logic [7:0]         data_q, data_d, sel_byte;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [N-1:0]       sel;
    rr_pick #(.N(N)) u_pick (
        .req   (req_valid),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .index (pick_idx)
    );
    always_comb begin
        sel = N'(1) << grant_q;
        req_ready = (state_q == LOAD && !tx_busy) ? sel : '0;
        xfer = |(req_valid & req_ready);
        sel_valid = |(req_valid & sel);
        sel_last = |(req_last & sel);
        sel_byte = '0;
        for (int i = 0; i < N; i++) if (sel[i]) sel_byte = req_data[8*i +: 8];
        ptr_nxt = (grant_q == GRANT_W'(N - 1)) ? '0 : grant_q + 1'b1;
        state_d = state_q;
        grant_d = grant_q;
        ptr_d = ptr_q;
        active_d = active_q;
        send_d = send_q;
        last_d = last_q;
        data_d = data_q;
        cnt_d = cnt_q;
        case (state_q)
            IDLE: if (!tx_busy && pick_valid) begin
                grant_d = pick_idx;
                active_d = 1'b1;
                cnt_d = '0;
                state_d = LOAD;
            end
            LOAD: if (xfer) begin
                data_d = sel_byte;
                send_d = 1'b1;
                last_d = sel_last;
                cnt_d = '0;
                state_d = SEND;
            end else if (!sel_valid) begin
                cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                // an idle requester mid-packet loses the UART so others are not starved
                if (TIMEOUT > 0 && cnt_d == TLIM) begin
                    active_d = 1'b0;
                    ptr_d = ptr_nxt;
                    cnt_d = '0;
                    state_d = IDLE;
                end
            end
            SEND: begin
                send_d = 1'b0;
                state_d = WAIT_HI;
            end
            WAIT_HI: state_d = tx_busy ? WAIT_LO : WAIT_HI;
            WAIT_LO: if (!tx_busy) begin
                active_d = last_q ? 1'b0 : active_q;
                ptr_d = last_q ? ptr_nxt : ptr_q;
                state_d = last_q ? IDLE : LOAD;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q <= '0;
            active_q <= 1'b0;
            send_q <= 1'b0;
            last_q <= 1'b0;
            data_q <= '0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q <= ptr_d;
            active_q <= active_d;
            send_q <= send_d;
            last_q <= last_d;
            data_q <= data_d;
            cnt_q <= cnt_d;
        end
    end
    assign tx_send = send_q;
    assign tx_data = data_q;
    assign grant_active = active_q;
    assign grant_id = grant_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of the arbiter against a behavioural 40-clk/frame uart_tx
module tb_uart_tx_arbiter;
    logic        clk, rst, tx_send, tx_busy, grant_active;
    logic [2:0]  req_valid, req_last, req_ready, grant_id, xfer;
    logic [23:0] req_data;
    logic [7:0]  tx_data;
    logic [8:0]  q0[$], q1[$], q2[$];
    logic [7:0]  log_b[$];
    logic [2:0]  log_g[$];
    int ucnt = 10;
    int total = 0, bad = 0;
    int nsend = 0, bad_send = 0, wide = 0, rdy_busy = 0;
    logic prev_send = 1'b0;
    int n, s0, early;

    uart_tx_arbiter #(.N(3), .TIMEOUT(20)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .tx_send(tx_send), .tx_data(tx_data), .tx_busy(tx_busy),
        .grant_active(grant_active), .grant_id(grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // uart_tx stand-in: no reset, busy at power-up, 40 busy cycles per accepted byte
    assign tx_busy = (ucnt != 0);
    always @(posedge clk) begin
        if (ucnt != 0) ucnt <= ucnt - 1;
        else if (tx_send) begin
            ucnt <= 40;
            log_b.push_back(tx_data);
            log_g.push_back(grant_id);
        end
    end

    always @(negedge clk) begin
        if (tx_send) nsend <= nsend + 1;
        if (tx_send && tx_busy) bad_send <= bad_send + 1;
        if (tx_send && prev_send) wide <= wide + 1;
        if ((|req_ready) && tx_busy) rdy_busy <= rdy_busy + 1;
        prev_send <= tx_send;
    end

    // requesters present the head of their queue and pop it on a transfer
    initial begin
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        forever begin
            @(negedge clk);
            xfer = req_valid & req_ready;
            @(posedge clk);
            #1;
            if (xfer[0]) void'(q0.pop_front());
            if (xfer[1]) void'(q1.pop_front());
            if (xfer[2]) void'(q2.pop_front());
            req_valid = {q2.size() != 0, q1.size() != 0, q0.size() != 0};
            req_last[0] = (q0.size() != 0) ? q0[0][8] : 1'b0;
            req_last[1] = (q1.size() != 0) ? q1[0][8] : 1'b0;
            req_last[2] = (q2.size() != 0) ? q2[0][8] : 1'b0;
            req_data[7:0] = (q0.size() != 0) ? q0[0][7:0] : 8'h00;
            req_data[15:8] = (q1.size() != 0) ? q1[0][7:0] : 8'h00;
            req_data[23:16] = (q2.size() != 0) ? q2[0][7:0] : 8'h00;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_log(input int cnt, input string tag);
        int t;
        t = 0;
        while (log_b.size() < cnt && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk(tag, log_b.size() >= cnt, 1);
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while ((grant_active || tx_busy || q0.size() + q1.size() + q2.size() != 0) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk(tag, !grant_active && !tx_busy, 1);
    endtask

    task automatic clear_logs;
        @(negedge clk);
        log_b.delete();
        log_g.delete();
    endtask

    initial begin
        rst = 1'b1;
        // 1: power-up with uart_tx still busy
        repeat (2) @(negedge clk);
        chk("rst_tx_send", tx_send, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_grant_active", grant_active, 0);
        chk("rst_grant_id", grant_id, 0);
        q0.push_back({1'b1, 8'h41});
        @(posedge clk);
        #1 rst = 1'b0;
        wait_log(1, "t1_wait");
        wait_idle("t1_idle");
        chk("t1_byte", log_b[0], 8'h41);
        chk("t1_gid", log_g[0], 0);
        chk("t1_nsend", nsend, 1);
        chk("t1_send_busy", bad_send, 0);
        chk("t1_released", grant_active, 0);
        // 2: 3-byte packet from req1 is not interrupted by req0
        clear_logs();
        q1.push_back({1'b0, 8'h48});
        q1.push_back({1'b0, 8'h49});
        q1.push_back({1'b1, 8'h0A});
        wait_log(1, "t2_first");
        q0.push_back({1'b1, 8'h42});
        wait_log(4, "t2_wait");
        wait_idle("t2_idle");
        chk("t2_b0", log_b[0], 8'h48);
        chk("t2_b1", log_b[1], 8'h49);
        chk("t2_b2", log_b[2], 8'h0A);
        chk("t2_b3", log_b[3], 8'h42);
        chk("t2_g2", log_g[2], 1);
        chk("t2_g3", log_g[3], 0);
        // 3: req2 packet first so the pointer wraps to 0, then all three contend twice
        clear_logs();
        q2.push_back({1'b1, 8'h20});
        wait_log(1, "t3_warm");
        @(negedge clk);
        for (int r = 0; r < 2; r++) begin
            q0.push_back({1'b1, 8'hA0 + 8'(r)});
            q1.push_back({1'b1, 8'hB0 + 8'(r)});
            q2.push_back({1'b1, 8'hC0 + 8'(r)});
        end
        wait_log(7, "t3_wait");
        wait_idle("t3_idle");
        chk("t3_order", {log_g[1], log_g[2], log_g[3], log_g[4], log_g[5], log_g[6]}, {3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2});
        chk("t3_bytes", {log_b[1], log_b[2], log_b[3], log_b[6]}, 32'hA0B0C0C1);
        chk("t3_wide", wide, 0);
        chk("t3_send_busy", bad_send, 0);
        // 4: req2 stalls mid-packet and is revoked after 20 LOAD cycles
        clear_logs();
        q2.push_back({1'b0, 8'h55});
        wait_log(1, "t4_first");
        q0.push_back({1'b1, 8'h30});
        n = 0;
        while (tx_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant_active && n < 100);
        chk("t4_revoke_cycles", n, 21);
        wait_log(2, "t4_wait");
        wait_idle("t4_idle");
        chk("t4_b0", log_b[0], 8'h55);
        chk("t4_b1", log_b[1], 8'h30);
        chk("t4_g1", log_g[1], 0);
        chk("t4_count", log_b.size(), 2);
        // 5: reset in WAIT_LO abandons the second byte
        clear_logs();
        q1.push_back({1'b0, 8'h11});
        q1.push_back({1'b1, 8'h22});
        wait_log(1, "t5_first");
        repeat (5) @(negedge clk);
        chk("t5_in_grant", grant_active && tx_busy, 1);
        q1.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_send", tx_send, 0);
        chk("t5_active", grant_active, 0);
        chk("t5_ready", req_ready, 0);
        q0.push_back({1'b1, 8'h77});
        early = 0;
        n = 0;
        while (tx_busy && n < 200) begin
            if (grant_active) early++;
            @(negedge clk);
            n++;
        end
        chk("t5_early_grant", early, 0);
        wait_log(2, "t5_wait");
        wait_idle("t5_idle");
        chk("t5_b0", log_b[0], 8'h11);
        chk("t5_b1", log_b[1], 8'h77);
        chk("t5_count", log_b.size(), 2);
        // 6: back-to-back packets from a single requester
        clear_logs();
        s0 = nsend;
        q0.push_back({1'b1, 8'h00});
        q0.push_back({1'b1, 8'hFF});
        wait_log(2, "t6_wait");
        wait_idle("t6_idle");
        chk("t6_b0", log_b[0], 8'h00);
        chk("t6_b1", log_b[1], 8'hFF);
        chk("t6_nsend", nsend - s0, 2);
        chk("t6_ready_busy", rdy_busy, 0);
        chk("t6_send_busy", bad_send, 0);
        chk("t6_wide", wide, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
